// File: rtl/sid_filter_pkg.sv
// Shared constants, coefficient tables, FSM encoding and helpers
// for the multi-channel SID state-variable filter.
package sid_filter_pkg;

  localparam int unsigned W0_BASE  = 797;
  localparam int unsigned W0_SLOPE = 40;
  localparam logic [11:0] FC_KNEE  = 12'hA37;
  localparam logic [17:0] W0_MAX   = 18'd105397;

  localparam int MODE_LP = 0;
  localparam int MODE_BP = 1;
  localparam int MODE_HP = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_BP,
    S_MUL_LP,
    S_MUL_HP,
    S_COMMIT
  } state_t;

  function automatic logic [10:0] q_lut(input logic [3:0] r);
    logic [10:0] q;
    case (r)
      4'd0:    q = 11'd1448;
      4'd1:    q = 11'd1323;
      4'd2:    q = 11'd1218;
      4'd3:    q = 11'd1128;
      4'd4:    q = 11'd1051;
      4'd5:    q = 11'd984;
      4'd6:    q = 11'd925;
      4'd7:    q = 11'd872;
      4'd8:    q = 11'd825;
      4'd9:    q = 11'd783;
      4'd10:   q = 11'd745;
      4'd11:   q = 11'd710;
      4'd12:   q = 11'd679;
      4'd13:   q = 11'd650;
      4'd14:   q = 11'd624;
      default: q = 11'd599;
    endcase
    return q;
  endfunction

  // Symmetric clamp to +/-(2^(w-1)-1); the most negative code is excluded.
  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

endpackage

// File: rtl/sid_svf_mc_if.sv
// Sample-in / result-out bundle of the multi-channel filter.
// The filter sits on the slave side, the sequencer on the master side.
interface sid_svf_mc_if #(
  parameter int NUM_CH = 3,
  parameter int DW     = 12
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [CHW-1:0]       in_ch;
  logic signed [DW-1:0] in;
  logic [11:0]          fc;
  logic [3:0]           resonance;
  logic [2:0]           mode;
  logic                 out_valid;
  logic [CHW-1:0]       out_ch;
  logic signed [DW-1:0] out;
  logic                 ovf;

  modport slave (
    input  in_valid, in_ch, in, fc, resonance, mode,
    output in_ready, out_valid, out_ch, out, ovf
  );

  modport master (
    output in_valid, in_ch, in, fc, resonance, mode,
    input  in_ready, out_valid, out_ch, out, ovf
  );

endinterface

// File: rtl/sid_filter_coef.sv
// Maps the cutoff and resonance codes to the w0 and Q coefficients.
// Purely combinational; feeds the accept latch of the filter.
module sid_filter_coef
  import sid_filter_pkg::*;
(
  input  logic [11:0] i_fc,
  input  logic [3:0]  i_res,
  output logic [17:0] o_w0,
  output logic [10:0] o_q
);

  logic [17:0] w_lin;

  assign w_lin = 18'(i_fc) * 18'(W0_SLOPE) + 18'(W0_BASE);
  assign o_w0  = (i_fc < FC_KNEE) ? w_lin : W0_MAX;
  assign o_q   = q_lut(i_res);

endmodule

// File: rtl/sid_svf_mc.sv
// Time-multiplexed LP/BP/HP/notch state-variable filter for NUM_CH
// channels, one shared signed multiplier, five cycles per sample.
module sid_svf_mc
  import sid_filter_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int DW      = 12,
  parameter int SW      = 24,
  parameter int W0_FRAC = 20,
  parameter int Q_FRAC  = 10
) (
  input  logic         clk,
  input  logic         reset,
  sid_svf_mc_if.slave  bus
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW  = SW + 19;
  localparam int AW  = SW + 2;
  localparam logic [CHW:0] NCH = (CHW + 1)'(NUM_CH);

  state_t r_state;
  state_t w_next;

  logic [CHW-1:0]       r_ch;
  logic signed [SW-1:0] r_in;
  logic [17:0]          r_w0;
  logic [10:0]          r_q;
  logic [2:0]           r_mode;

  logic signed [SW-1:0] r_vhp [NUM_CH];
  logic signed [SW-1:0] r_vbp [NUM_CH];
  logic signed [SW-1:0] r_vlp [NUM_CH];

  logic signed [AW-1:0] r_pbp;
  logic signed [AW-1:0] r_plp;
  logic signed [AW-1:0] r_phq;

  logic                 r_out_valid;
  logic [CHW-1:0]       r_out_ch;
  logic signed [DW-1:0] r_out;
  logic                 r_ovf;

  logic [17:0] w_w0;
  logic [10:0] w_q;
  logic        w_accept;
  logic        w_ch_ok;

  logic signed [SW-1:0] w_vhp;
  logic signed [SW-1:0] w_vbp;
  logic signed [SW-1:0] w_vlp;

  logic signed [18:0]   w_opa;
  logic signed [SW-1:0] w_opb;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_prod_t;

  logic signed [AW-1:0] w_bp_raw;
  logic signed [AW-1:0] w_lp_raw;
  logic signed [AW-1:0] w_hp_raw;
  logic signed [SW-1:0] w_bp_n;
  logic signed [SW-1:0] w_lp_n;
  logic signed [SW-1:0] w_hp_n;
  logic signed [AW-1:0] w_hp_x;
  logic signed [AW-1:0] w_bp_x;
  logic signed [AW-1:0] w_lp_x;
  logic signed [AW-1:0] w_sum;
  logic signed [DW-1:0] w_out_n;
  logic                 w_clip;

  sid_filter_coef u_coef (
    .i_fc  (bus.fc),
    .i_res (bus.resonance),
    .o_w0  (w_w0),
    .o_q   (w_q)
  );

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_ch_ok  = ({1'b0, bus.in_ch} < NCH);

  assign w_vhp = r_vhp[r_ch];
  assign w_vbp = r_vbp[r_ch];
  assign w_vlp = r_vlp[r_ch];

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept && w_ch_ok) w_next = S_MUL_BP;
      S_MUL_BP: w_next = S_MUL_LP;
      S_MUL_LP: w_next = S_MUL_HP;
      S_MUL_HP: w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Shared multiplier: operand pair and shift chosen by the FSM phase.
  always_comb begin
    w_opa = {1'b0, r_w0};
    w_opb = w_vhp;
    unique case (r_state)
      S_MUL_LP: w_opb = w_vbp;
      S_MUL_HP: begin
        w_opa = {8'b0, r_q};
        w_opb = w_vbp;
      end
      default: ;
    endcase
    w_prod = PW'(w_opa) * PW'(w_opb);
    if (r_state == S_MUL_HP)
      w_prod_t = AW'(w_prod >>> Q_FRAC);
    else
      w_prod_t = AW'(w_prod >>> W0_FRAC);
  end

  always_comb begin
    w_bp_raw = AW'(w_vbp) - r_pbp;
    w_lp_raw = AW'(w_vlp) - r_plp;
    w_hp_raw = r_phq - AW'(w_vlp) + AW'(r_in);
    w_bp_n   = SW'(sat(64'(w_bp_raw), SW));
    w_lp_n   = SW'(sat(64'(w_lp_raw), SW));
    w_hp_n   = SW'(sat(64'(w_hp_raw), SW));
    w_hp_x   = '0;
    w_bp_x   = '0;
    w_lp_x   = '0;
    if (r_mode[MODE_HP]) w_hp_x = AW'(w_hp_n);
    if (r_mode[MODE_BP]) w_bp_x = AW'(w_bp_n);
    if (r_mode[MODE_LP]) w_lp_x = AW'(w_lp_n);
    w_sum   = w_hp_x + w_bp_x + w_lp_x;
    w_out_n = DW'(sat(64'(w_sum), DW));
    w_clip  = (sat(64'(w_bp_raw), SW) != 64'(w_bp_raw))
           || (sat(64'(w_lp_raw), SW) != 64'(w_lp_raw))
           || (sat(64'(w_hp_raw), SW) != 64'(w_hp_raw))
           || (sat(64'(w_sum), DW)    != 64'(w_sum));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_vhp[i] <= '0;
        r_vbp[i] <= '0;
        r_vlp[i] <= '0;
      end
      r_ch        <= '0;
      r_in        <= '0;
      r_w0        <= '0;
      r_q         <= '0;
      r_mode      <= '0;
      r_pbp       <= '0;
      r_plp       <= '0;
      r_phq       <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept && w_ch_ok) begin
        r_ch   <= bus.in_ch;
        r_in   <= SW'(bus.in);
        r_w0   <= w_w0;
        r_q    <= w_q;
        r_mode <= bus.mode;
      end
      unique case (r_state)
        S_MUL_BP: r_pbp <= w_prod_t;
        S_MUL_LP: r_plp <= w_prod_t;
        S_MUL_HP: r_phq <= w_prod_t;
        S_COMMIT: begin
          r_vbp[r_ch] <= w_bp_n;
          r_vlp[r_ch] <= w_lp_n;
          r_vhp[r_ch] <= w_hp_n;
          r_out       <= w_out_n;
          r_out_ch    <= r_ch;
          r_out_valid <= 1'b1;
          if (w_clip) r_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
  assign bus.out       = r_out;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_sid_svf_mc.sv
// Randomised bench for sid_svf_mc against an arithmetic reference
// of the filter equations, one expected result per accepted sample.
module tb_sid_svf_mc;

  logic clk;
  logic reset;

  sid_svf_mc_if #(.NUM_CH(3), .DW(12)) bus ();

  sid_svf_mc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  localparam longint SLIM = (64'sd1 <<< 23) - 1;
  localparam longint OLIM = 2047;

  int qtab [16] = '{1448, 1323, 1218, 1128, 1051, 984, 925, 872,
                    825, 783, 745, 710, 679, 650, 624, 599};

  longint mvhp [3];
  longint mvbp [3];
  longint mvlp [3];
  bit     movf;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mvhp[i] = 0;
      mvbp[i] = 0;
      mvlp[i] = 0;
    end
    movf = 1'b0;
  endfunction

  function automatic longint clampv(input longint v, input longint lim);
    if (v > lim) begin
      movf = 1'b1;
      return lim;
    end
    if (v < -lim) begin
      movf = 1'b1;
      return -lim;
    end
    return v;
  endfunction

  function automatic longint model_step(input int ch, input int din,
                                        input int fc, input int res,
                                        input int md);
    longint w, q, pbp, plp, phq, nbp, nlp, nhp, sum;
    w   = (fc < 'hA37) ? longint'(fc) * 40 + 797 : 105397;
    q   = qtab[res];
    pbp = (w * mvhp[ch]) >>> 20;
    plp = (w * mvbp[ch]) >>> 20;
    phq = (mvbp[ch] * q) >>> 10;
    nbp = clampv(mvbp[ch] - pbp, SLIM);
    nlp = clampv(mvlp[ch] - plp, SLIM);
    nhp = clampv(phq - mvlp[ch] + din, SLIM);
    mvbp[ch] = nbp;
    mvlp[ch] = nlp;
    mvhp[ch] = nhp;
    sum = 0;
    if (md[2]) sum += nhp;
    if (md[1]) sum += nbp;
    if (md[0]) sum += nlp;
    return clampv(sum, OLIM);
  endfunction

  longint last_out;

  // Entered and left on a falling edge; junk drives in_valid through the busy window.
  task automatic run(input int ch, input int din, input int fc,
                     input int res, input int md, input bit junk);
    longint exp_out;
    int     nv, lat, rdy_low;
    longint got_out;
    int     got_ch;
    bus.in_valid  = 1'b1;
    bus.in_ch     = 2'(ch);
    bus.in        = 12'(din);
    bus.fc        = 12'(fc);
    bus.resonance = 4'(res);
    bus.mode      = 3'(md);
    exp_out = 0;
    if (ch < 3) exp_out = model_step(ch, din, fc, res, md);
    @(posedge clk);
    #1;
    if (junk) begin
      bus.in_ch = 2'd1;
      bus.in    = 12'sd999;
      bus.mode  = 3'd7;
      bus.fc    = 12'h123;
    end else begin
      bus.in_valid = 1'b0;
    end
    nv = 0; lat = 0; rdy_low = 0; got_out = 0; got_ch = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        nv++;
        if (lat == 0) begin
          lat     = k;
          got_out = bus.out;
          got_ch  = int'(bus.out_ch);
        end
      end
      if (!bus.in_ready) rdy_low++;
      if (ch < 3 && k == 1) chk("ready_busy", bus.in_ready, 0);
      if (ch < 3 && k == 5) chk("ready_back", bus.in_ready, 1);
      if (k == 5) bus.in_valid = 1'b0;
    end
    if (ch < 3) begin
      chk("latency", lat, 5);
      chk("n_valid", nv, 1);
      chk("out", got_out, exp_out);
      chk("out_ch", got_ch, ch);
      chk("ovf", bus.ovf, movf);
      chk("out_hold", bus.out, exp_out);
      last_out = got_out;
    end else begin
      chk("inv_valid", nv, 0);
      chk("inv_ready", rdy_low, 0);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in        = '0;
    bus.fc        = '0;
    bus.resonance = '0;
    bus.mode      = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_out_ch", bus.out_ch, 0);
    chk("rst_ovf", bus.ovf, 0);

    run(0, 100, 'hFFF, 0, 4, 0);
    chk("hp_step", last_out, 100);
    run(0, 100, 'hFFF, 0, 2, 0);
    chk("bp_step", last_out, -10);

    run(1, 100, 'hFFF, 0, 4, 0);
    chk("ch1_iso", last_out, 100);
    run(0, 37, 'h400, 5, 7, 0);

    run(2, 50, 100, 3, 5, 1);
    run(3, 500, 0, 0, 7, 0);
    run(0, -300, 'h800, 9, 1, 0);
    run(1, 250, 'h200, 2, 2, 0);
    run(2, 1000, 'hA36, 15, 5, 0);

    for (int i = 0; i < 60; i++)
      run($urandom_range(0, 2), $urandom_range(0, 4095) - 2048,
          $urandom_range(0, 4095), $urandom_range(0, 15),
          $urandom_range(0, 7), 1'($urandom_range(0, 1)));

    // Reset lands while the sample is in MUL_LP; no result may escape.
    bus.in_valid = 1'b1;
    bus.in_ch    = 2'd0;
    bus.in       = 12'sd123;
    bus.mode     = 3'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_out", bus.out, 0);
    chk("mid_rst_ovf", bus.ovf, 0);
    begin
      int nv;
      nv = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (bus.out_valid) nv++;
      end
      chk("mid_rst_no_valid", nv, 0);
    end
    run(0, 100, 0, 0, 4, 0);
    chk("post_rst_hp", last_out, 100);

    for (int i = 0; i < 200; i++) begin
      run(0, 2047, 'hFFF, 15, 7, 0);
      chk("sat_no_min", (last_out == -2048) ? 1 : 0, 0);
    end
    run(1, 0, 'h100, 0, 7, 0);
    run(2, 0, 'h100, 0, 7, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
